// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Holds the PC, runs a req/ack handshake with instruction memory, and presents one
// fetched instruction per cycle to decode. A one-entry skid buffer absorbs the word
// that arrives while decode is stalled; redirects flush the pipe and refetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,

    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_op_code,
    output logic [31:0] if_pc_plus4
);

    // StReq:  request outstanding at addr_q
    // StFull: skid holds a word, no request
    // StDrop: request outstanding to a stale address; its data will be thrown away
    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StFull = 2'd1,
        StDrop = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        ack_v;
    logic        slot_free;
    logic [31:0] addr_inc;
    logic [31:0] target;

    // Acks only count while a request is actually visible on the bus.
    assign imem_req  = req_q & rst_n;
    assign imem_addr = addr_q;
    assign ack_v     = imem_ack & imem_req;
    assign slot_free = !if_valid_q || !stall;
    assign addr_inc  = addr_q + 32'd4;
    assign target    = {redirect_pc[31:2], 2'b00};

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_op_code  = if_instr_q[31:26];
    assign if_pc_plus4 = if_pc4_q;

    // Next-state: redirect first, then the per-state handshake.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (redirect) begin
            if_valid_d   = 1'b0;
            skid_instr_d = 32'h0;
            skid_pc4_d   = 32'h0;
            pc_d         = target;
            // With nothing pending on the bus the target can be issued directly;
            // otherwise the in-flight request must complete before it can move.
            if (state_q == StFull || ack_v || !imem_req) begin
                addr_d  = target;
                state_d = StReq;
            end else begin
                state_d = StDrop;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    if (ack_v) begin
                        addr_d = addr_inc;
                        pc_d   = addr_inc;
                        if (slot_free) begin
                            if_instr_d = imem_rdata;
                            if_pc4_d   = addr_inc;
                            if_valid_d = 1'b1;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = addr_inc;
                            state_d      = StFull;
                        end
                    end else if (!stall) begin
                        // Decode consumed the current word and nothing replaces it.
                        if_valid_d = 1'b0;
                    end
                end
                StFull: begin
                    if (!stall) begin
                        if_instr_d   = skid_instr_q;
                        if_pc4_d     = skid_pc4_q;
                        if_valid_d   = 1'b1;
                        skid_instr_d = 32'h0;
                        skid_pc4_d   = 32'h0;
                        state_d      = StReq;
                    end
                end
                StDrop: begin
                    if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                    if (ack_v) begin
                        addr_d  = pc_q;
                        state_d = StReq;
                    end
                end
                default: begin
                    state_d = StReq;
                end
            endcase
        end

        req_d = (state_d != StFull);
    end

    // State and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StReq;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0;
            if_pc4_q     <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances share stimulus, one with the default
// reset PC and one starting at the top of the address space to exercise wrap-around.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        val0, val1;
    logic [31:0] instr0, instr1;
    logic [5:0]  op0, op1;
    logic [31:0] pc4_0, pc4_1;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] W0 = 32'h8C08_0004;
    localparam logic [31:0] W1 = 32'h2009_0001;
    localparam logic [31:0] X1 = 32'h3C01_1234;
    localparam logic [31:0] X2 = 32'hAC02_0008;
    localparam logic [31:0] X3 = 32'h0800_0010;
    localparam logic [31:0] X4 = 32'h2129_0002;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    fetch_stage dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req0),
        .imem_addr   (addr0),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (val0),
        .if_instr    (instr0),
        .if_op_code  (op0),
        .if_pc_plus4 (pc4_0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req1),
        .imem_addr   (addr1),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (val1),
        .if_instr    (instr1),
        .if_op_code  (op1),
        .if_pc_plus4 (pc4_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset state
        step(); step();
        chk("rst_req",   {31'h0, req0}, 32'h0);
        chk("rst_valid", {31'h0, val0}, 32'h0);
        chk("rst_instr", instr0, 32'h0);
        chk("rst_pc4",   pc4_0, 32'h0);
        chk("rst_addr",  addr0, 32'h0);
        chk("rst_addr1", addr1, 32'hFFFF_FFFC);

        // Release: request appears one cycle later
        rst_n = 1'b1;
        #1;
        chk("rel_req_low", {31'h0, req0}, 32'h0);
        step();
        chk("rel_req_hi", {31'h0, req0}, 32'h1);
        chk("rel_addr",   addr0, 32'h0);

        // 1: zero-wait memory, back-to-back words
        imem_ack = 1'b1; imem_rdata = W0;
        step();
        chk("t1_op0",   {26'h0, op0}, 32'h23);
        chk("t1_pc4_0", pc4_0, 32'h4);
        chk("t1_addr0", addr0, 32'h4);
        chk("t1_val0",  {31'h0, val0}, 32'h1);
        chk("t6_pc4_wrap",  pc4_1, 32'h0);
        chk("t6_addr_wrap", addr1, 32'h0);
        imem_rdata = W1;
        step();
        chk("t1_op1",   {26'h0, op0}, 32'h08);
        chk("t1_pc4_1", pc4_0, 32'h8);
        chk("t1_addr1", addr0, 32'h8);
        chk("t6_addr_next", addr1, 32'h4);
        imem_ack = 1'b0;
        step();
        chk("t1_drain_val", {31'h0, val0}, 32'h0);

        // 2: ack delayed 3 cycles, request held stable
        step();
        chk("t2_req_w1",  {31'h0, req0}, 32'h1);
        chk("t2_addr_w1", addr0, 32'h8);
        step();
        chk("t2_req_w2",  {31'h0, req0}, 32'h1);
        chk("t2_addr_w2", addr0, 32'h8);
        chk("t2_val_w2",  {31'h0, val0}, 32'h0);
        imem_ack = 1'b1; imem_rdata = X1;
        step();
        chk("t2_val",   {31'h0, val0}, 32'h1);
        chk("t2_instr", instr0, X1);
        chk("t2_pc4",   pc4_0, 32'hC);
        chk("t2_addr",  addr0, 32'hC);
        imem_ack = 1'b0;

        // 3: stall with live word, ack goes into the skid buffer
        stall = 1'b1;
        step();
        chk("t3_hold_val",   {31'h0, val0}, 32'h1);
        chk("t3_hold_instr", instr0, X1);
        imem_ack = 1'b1; imem_rdata = X2;
        step();
        chk("t3_full_req",   {31'h0, req0}, 32'h0);
        chk("t3_full_instr", instr0, X1);
        chk("t3_full_pc4",   pc4_0, 32'hC);
        chk("t3_full_addr",  addr0, 32'h10);
        imem_ack = 1'b0;
        step();
        chk("t3_full_req2",  {31'h0, req0}, 32'h0);
        chk("t3_full_val2",  {31'h0, val0}, 32'h1);
        stall = 1'b0;
        step();
        chk("t3_skid_instr", instr0, X2);
        chk("t3_skid_pc4",   pc4_0, 32'h10);
        chk("t3_skid_val",   {31'h0, val0}, 32'h1);
        chk("t3_req_back",   {31'h0, req0}, 32'h1);
        chk("t3_addr_back",  addr0, 32'h10);

        // 4: redirect while 0x10 is pending, stale ack dropped
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        chk("t4_flush_val", {31'h0, val0}, 32'h0);
        chk("t4_drop_addr", addr0, 32'h10);
        chk("t4_drop_req",  {31'h0, req0}, 32'h1);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = BAD;
        step();
        chk("t4_bad_val",   {31'h0, val0}, 32'h0);
        chk("t4_bad_instr", instr0, X2);
        chk("t4_new_addr",  addr0, 32'h40);
        imem_rdata = X3;
        step();
        chk("t4_tgt_instr", instr0, X3);
        chk("t4_tgt_pc4",   pc4_0, 32'h44);
        chk("t4_tgt_addr",  addr0, 32'h44);

        // 5: redirect beats stall, ack in the same cycle is discarded
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h103; imem_rdata = BAD;
        step();
        chk("t5_val",  {31'h0, val0}, 32'h0);
        chk("t5_addr", addr0, 32'h100);
        chk("t5_req",  {31'h0, req0}, 32'h1);
        stall = 1'b0; redirect = 1'b0; imem_rdata = X4;
        step();
        chk("t5_instr", instr0, X4);
        chk("t5_pc4",   pc4_0, 32'h104);
        chk("t5_addr2", addr0, 32'h104);

        // 6: reset during a wait abandons the transaction
        imem_ack = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_req_forced", {31'h0, req0}, 32'h0);
        step();
        chk("t6_rst_val",   {31'h0, val0}, 32'h0);
        chk("t6_rst_addr0", addr0, 32'h0);
        chk("t6_rst_addr1", addr1, 32'hFFFF_FFFC);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = BAD;
        step();
        chk("t6_ign_val",  {31'h0, val0}, 32'h0);
        chk("t6_ign_addr", addr0, 32'h0);
        chk("t6_req_up",   {31'h0, req0}, 32'h1);
        imem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
